// File: rtl/bus_xfer_if.sv
// Request and register-bus signal bundle between the decoder side and bus_xfer_ctrl.
// The master modport is the requester and bus model; the slave modport is the sequencer.
interface bus_xfer_if #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ID_W     = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [ID_W-1:0]     req_src;
    logic [ID_W-1:0]     req_dst;
    logic                req_bus_b;
    logic                req_imm_en;
    logic [DATA_W-1:0]   req_imm;
    logic [DATA_W-1:0]   bus_a_in;
    logic [DATA_W-1:0]   bus_b_in;
    logic [NUM_REGS-1:0] out_a_en;
    logic [NUM_REGS-1:0] out_b_en;
    logic [NUM_REGS-1:0] write_en;
    logic [DATA_W-1:0]   data_out;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_src, req_dst, req_bus_b, req_imm_en, req_imm,
        output bus_a_in, bus_b_in,
        input  req_ready, out_a_en, out_b_en, write_en, data_out, done, err
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_bus_b, req_imm_en, req_imm,
        input  bus_a_in, bus_b_in,
        output req_ready, out_a_en, out_b_en, write_en, data_out, done, err
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Sequencer for the shared register buses: drives a source onto bus A/B, captures the
// bus value, then writes it (or an immediate) into the destination register.
module bus_xfer_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ID_W     = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    bus_xfer_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [ID_W:0]       REG_LIMIT = (ID_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);

    logic [2:0]          state_r;
    logic [2:0]          state_nx_s;
    logic [ID_W-1:0]     src_r;
    logic [ID_W-1:0]     dst_r;
    logic                bus_b_r;
    logic                err_r;
    logic [DATA_W-1:0]   hold_r;
    logic                ready_s;
    logic                accept_s;
    logic                err_req_s;
    logic [NUM_REGS-1:0] oe_a_s;
    logic [NUM_REGS-1:0] oe_b_s;
    logic [NUM_REGS-1:0] we_s;

    // ready is gated by reset_n so nothing is offered while reset is held
    assign ready_s   = reset_n && ((state_r == ST_IDLE) || (state_r == ST_FIN));
    assign accept_s  = bus.req_valid && ready_s;
    assign err_req_s = (({1'b0, bus.req_src} >= REG_LIMIT) && !bus.req_imm_en)
                     || ({1'b0, bus.req_dst} >= REG_LIMIT)
                     || ((bus.req_src == bus.req_dst) && !bus.req_imm_en);

    // Next-state selection; FIN re-enters a new transfer directly when one is accepted
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (accept_s) begin
                    if (err_req_s) begin
                        state_nx_s = ST_FIN;
                    end else if (bus.req_imm_en) begin
                        state_nx_s = ST_WRITE;
                    end else begin
                        state_nx_s = ST_DRIVE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE: state_nx_s = ST_LATCH;
            ST_LATCH: state_nx_s = ST_WRITE;
            ST_WRITE: state_nx_s = ST_FIN;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State, latched request fields and hold register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            src_r   <= '0;
            dst_r   <= '0;
            bus_b_r <= 1'b0;
            err_r   <= 1'b0;
            hold_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                src_r   <= bus.req_src;
                dst_r   <= bus.req_dst;
                bus_b_r <= bus.req_bus_b;
                err_r   <= err_req_s;
                if (bus.req_imm_en && !err_req_s) begin
                    hold_r <= bus.req_imm;
                end else begin
                    hold_r <= hold_r;
                end
            end else if (state_r == ST_LATCH) begin
                hold_r <= bus_b_r ? bus.bus_b_in : bus.bus_a_in;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Enables come only from registers, so an async reset clears them at once
    always_comb begin
        oe_a_s = '0;
        oe_b_s = '0;
        we_s   = '0;
        if ((state_r == ST_DRIVE) || (state_r == ST_LATCH)) begin
            if (bus_b_r) begin
                oe_b_s = ONE_HOT0 << src_r;
            end else begin
                oe_a_s = ONE_HOT0 << src_r;
            end
        end else if (state_r == ST_WRITE) begin
            we_s = ONE_HOT0 << dst_r;
        end else begin
            we_s = '0;
        end
    end

    // hold_r only changes on edges entering WRITE, so data_out keeps the last written value
    assign bus.req_ready = ready_s;
    assign bus.out_a_en  = oe_a_s;
    assign bus.out_b_en  = oe_b_s;
    assign bus.write_en  = we_s;
    assign bus.data_out  = hold_r;
    assign bus.done      = (state_r == ST_FIN);
    assign bus.err       = (state_r == ST_FIN) && err_r;
endmodule
